// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
// rst_seq_state_e : sequencer phases (Sync, Hold, Release, Run), 2-bit encoded.
// rst_seq_cnt_width : width of the hold/step counter, sized for the larger of the two intervals.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    Sync    = 2'd0,
    Hold    = 2'd1,
    Release = 2'd2,
    Run     = 2'd3
  } rst_seq_state_e;

  // The smallest width that can hold the larger interval
  // (so it also holds that interval minus one).
  localparam int unsigned MinCntWidth = 1;

  function automatic int unsigned rst_seq_cnt_width(int unsigned holdCycles,
                                                     int unsigned stepCycles);
    int unsigned maxVal;
    int unsigned w;
    maxVal = (holdCycles > stepCycles) ? holdCycles : stepCycles;
    w = $clog2(maxVal + 1);
    return (w < MinCntWidth) ? MinCntWidth : w;
  endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser with asynchronous active-low reset.
// clk_i  : destination clock
// rst_ni : asynchronous active-low reset, loads ResetValue into both stages
// d_i    : asynchronous input
// q_o    : input re-timed through two flops
module prim_flop_2sync #(
  parameter int unsigned           Width      = 1,
  parameter logic [Width-1:0]      ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] firstStage_q;
  logic [Width-1:0] secondStage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      firstStage_q  <= ResetValue;
      secondStage_q <= ResetValue;
    end else begin
      firstStage_q  <= d_i;
      secondStage_q <= firstStage_q;
    end
  end

  assign q_o = secondStage_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for a single clock domain.
// The board reset asserts every output immediately; its release is re-timed through a
// synchroniser, stretched for HoldCycles, and the outputs are then released one by one in
// ascending order, StepCycles apart. Synchronous reset requests re-run the sequence.
// A sticky cause register records which source caused a reset.
// clk_i       : domain clock
// rst_ni      : board reset, asynchronous active-low
// rst_req_i   : synchronous reset requests, any bit set restarts the sequence
// cause_clr_i : synchronous clear of cause_o
// rst_no      : sequenced active-low resets, straight from flops
// busy_o      : high while any rst_no bit is still asserted
// cause_o     : sticky cause, bit0 = rst_ni, bit i+1 = rst_req_i[i]
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NumRst     = 3,
  parameter int unsigned NumReq     = 2,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned HoldCycles = 16,
  parameter int unsigned StepCycles = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] rst_req_i,
  input  logic              cause_clr_i,
  output logic [NumRst-1:0] rst_no,
  output logic              busy_o,
  output logic [NumReq:0]   cause_o
);

  localparam int unsigned    CntW     = rst_seq_cnt_width(HoldCycles, StepCycles);
  localparam int unsigned    IdxW     = $clog2(NumRst) + 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] StepLast = CntW'(StepCycles - 1);
  localparam logic [CntW-1:0] CntMax   = '1;

  rst_seq_state_e    state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   relIdx_q, relIdx_d;
  logic [NumRst-1:0] rst_q, rst_d;
  logic [NumReq:0]   cause_q, cause_d;

  logic syncMid;
  logic syncOut;
  logic reqAny;
  logic releaseFirst;
  logic [CntW-1:0] cntInc;

  // Deassertion synchroniser: a constant 1 shifted in behind the async reset.
  prim_flop_2sync #(
    .Width     (1),
    .ResetValue(1'b0)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (1'b1),
    .q_o   (syncMid)
  );

  generate
    if (SyncStages > 2) begin : g_extraStages
      logic [SyncStages-3:0] extra_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          extra_q <= '0;
        end else begin
          extra_q[0] <= syncMid;
          for (int i = 1; i < int'(SyncStages) - 2; i++) begin
            extra_q[i] <= extra_q[i-1];
          end
        end
      end

      assign syncOut = extra_q[SyncStages-3];
    end else begin : g_noExtraStages
      assign syncOut = syncMid;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= Sync;
      cnt_q    <= '0;
      relIdx_q <= '0;
      rst_q    <= '0;
      cause_q  <= (NumReq + 1)'(1);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      relIdx_q <= relIdx_d;
      rst_q    <= rst_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    relIdx_d     = relIdx_q;
    rst_d        = rst_q;
    releaseFirst = 1'b0;
    reqAny       = |rst_req_i;
    cntInc       = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);

    unique case (state_q)
      // The edge that first sees the synchroniser high is already the first hold
      // cycle, so the first output rises HoldCycles edges after the chain output does.
      Sync: begin
        if (syncOut) begin
          if (HoldCycles == 1) begin
            releaseFirst = 1'b1;
          end else begin
            state_d = Hold;
            cnt_d   = CntW'(1);
          end
        end
      end
      Hold: begin
        if (cnt_q == HoldLast) begin
          releaseFirst = 1'b1;
        end else begin
          cnt_d = cntInc;
        end
      end
      Release: begin
        if (cnt_q == StepLast) begin
          for (int i = 0; i < int'(NumRst); i++) begin
            if (relIdx_q == IdxW'(i)) begin
              rst_d[i] = 1'b1;
            end
          end
          relIdx_d = relIdx_q + IdxW'(1);
          cnt_d    = '0;
          if (relIdx_q == IdxW'(NumRst - 1)) begin
            state_d = Run;
          end
        end else begin
          cnt_d = cntInc;
        end
      end
      Run: begin
      end
      default: begin
        state_d = Sync;
      end
    endcase

    if (releaseFirst) begin
      rst_d[0] = 1'b1;
      cnt_d    = '0;
      relIdx_d = IdxW'(1);
      state_d  = (NumRst == 1) ? Run : Release;
    end

    // A request outranks any pending release; during Sync it is only recorded.
    if (reqAny && (state_q != Sync)) begin
      rst_d    = '0;
      cnt_d    = '0;
      relIdx_d = '0;
      state_d  = Hold;
    end

    // A set in the same cycle as a clear survives the clear.
    cause_d = (cause_clr_i ? '0 : cause_q) | {rst_req_i, 1'b0};
  end

  assign rst_no  = rst_q;
  assign busy_o  = ~(&rst_q);
  assign cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl.
// A default-parameter instance is compared every cycle against a timing model that
// derives each output from the number of edges since the sequence last started.
// A second instance (NumRst=1, HoldCycles=1, SyncStages=3) is pinned with literal checks.
module tb_rst_seq_ctrl;

  localparam int TbNumRst = 3;
  localparam int TbSync   = 2;
  localparam int TbHold   = 16;
  localparam int TbStep   = 4;

  logic       clk;
  logic       rst_ni;
  logic [1:0] rstReq;
  logic       causeClr;
  logic [2:0] rstNo;
  logic       busy;
  logic [2:0] cause;
  logic [0:0] rstNo2;
  logic       busy2;
  logic [2:0] cause2;

  int nChecks = 0;
  int nErrors = 0;
  bit checkEnable = 0;

  rst_seq_ctrl u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rst_req_i  (rstReq),
    .cause_clr_i(causeClr),
    .rst_no     (rstNo),
    .busy_o     (busy),
    .cause_o    (cause)
  );

  rst_seq_ctrl #(
    .NumRst    (1),
    .NumReq    (2),
    .SyncStages(3),
    .HoldCycles(1),
    .StepCycles(4)
  ) u_dut2 (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .rst_req_i  (2'b00),
    .cause_clr_i(1'b0),
    .rst_no     (rstNo2),
    .busy_o     (busy2),
    .cause_o    (cause2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timing model: while the synchroniser is still filling, everything is held.
  // Afterwards 'since' counts edges since the sequence started (the synchroniser
  // release edge, or the last edge that saw a request); output i is released once
  // since >= hold + i*step.
  int         edgeNum = 0;
  bit         inSync  = 1;
  int         since   = 0;
  logic [2:0] mCause  = 3'b001;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      edgeNum <= 0;
      inSync  <= 1;
      since   <= 0;
      mCause  <= 3'b001;
    end else begin
      edgeNum <= edgeNum + 1;
      // The current edge is edgeNum+1; the block leaves Sync on edge TbSync+1,
      // one edge after the sequence start, and ignores requests until then.
      if (inSync) begin
        if (edgeNum == TbSync) begin
          inSync <= 0;
          since  <= 1;
        end
      end else if (|rstReq) begin
        since <= 0;
      end else if (since < 10000) begin
        since <= since + 1;
      end
      mCause <= (causeClr ? 3'b000 : mCause) | {rstReq, 1'b0};
    end
  end

  function automatic logic [2:0] expRst();
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < TbNumRst; i++) begin
      if (!inSync && (since >= TbHold + i * TbStep)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic expBusy();
    return inSync || (since < TbHold + (TbNumRst - 1) * TbStep);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic clr);
    rstReq   = req;
    causeClr = clr;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every-cycle comparison against the model, on the inactive edge.
  always @(negedge clk) begin
    if (checkEnable) begin
      checkOutput("model rst_no", {5'b0, rstNo}, {5'b0, expRst()});
      checkOutput("model busy", {7'b0, busy}, {7'b0, expBusy()});
      checkOutput("model cause", {5'b0, cause}, {5'b0, mCause});
    end
  end

  task automatic randomPhase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      logic [1:0] r;
      r = 2'b00;
      if ($urandom_range(0, 24) == 0) r = 2'($urandom_range(1, 3));
      applyStimulus(r, ($urandom_range(0, 9) == 0));
      waitEdges(1);
    end
    applyStimulus(2'b00, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0;
    applyStimulus(2'b00, 1'b0);
    waitEdges(1);
    checkEnable = 1;
    waitEdges(4);
    checkOutput("por rst_no low", {5'b0, rstNo}, 8'h00);
    checkOutput("por busy", {7'b0, busy}, 8'h01);
    checkOutput("por cause", {5'b0, cause}, 8'h01);

    // POR release; edges are counted from here.
    @(negedge clk);
    #1 rst_ni = 1'b1;
    waitEdges(3);
    checkOutput("p1 rst_no edge3", {7'b0, rstNo2}, 8'h00);
    checkOutput("p1 busy edge3", {7'b0, busy2}, 8'h01);
    waitEdges(1);
    checkOutput("p1 rst_no edge4", {7'b0, rstNo2}, 8'h01);
    checkOutput("p1 busy edge4", {7'b0, busy2}, 8'h00);
    checkOutput("p1 cause", {5'b0, cause2}, 8'h01);
    waitEdges(13);
    checkOutput("por edge17", {5'b0, rstNo}, 8'h00);
    waitEdges(1);
    checkOutput("por edge18", {5'b0, rstNo}, 8'h01);
    waitEdges(3);
    checkOutput("por edge21", {5'b0, rstNo}, 8'h01);
    waitEdges(1);
    checkOutput("por edge22", {5'b0, rstNo}, 8'h03);
    waitEdges(3);
    checkOutput("por edge25 busy", {7'b0, busy}, 8'h01);
    waitEdges(1);
    checkOutput("por edge26", {5'b0, rstNo}, 8'h07);
    checkOutput("por edge26 busy", {7'b0, busy}, 8'h00);
    checkOutput("por cause final", {5'b0, cause}, 8'h01);

    // Request in Run.
    applyStimulus(2'b01, 1'b0);
    waitEdges(1);
    applyStimulus(2'b00, 1'b0);
    checkOutput("req k rst_no", {5'b0, rstNo}, 8'h00);
    checkOutput("req k busy", {7'b0, busy}, 8'h01);
    checkOutput("req cause", {5'b0, cause}, 8'h03);
    waitEdges(15);
    checkOutput("req k+15", {5'b0, rstNo}, 8'h00);
    waitEdges(1);
    checkOutput("req k+16", {5'b0, rstNo}, 8'h01);
    waitEdges(4);
    checkOutput("req k+20", {5'b0, rstNo}, 8'h03);
    waitEdges(4);
    checkOutput("req k+24", {5'b0, rstNo}, 8'h07);

    // Request while outputs are partially released.
    applyStimulus(2'b01, 1'b0);
    waitEdges(1);
    applyStimulus(2'b00, 1'b0);
    waitEdges(20);
    checkOutput("mid pre", {5'b0, rstNo}, 8'h03);
    applyStimulus(2'b10, 1'b0);
    waitEdges(1);
    applyStimulus(2'b00, 1'b0);
    checkOutput("mid reassert", {5'b0, rstNo}, 8'h00);
    checkOutput("mid cause", {5'b0, cause}, 8'h07);
    waitEdges(15);
    checkOutput("mid +15", {5'b0, rstNo}, 8'h00);
    waitEdges(1);
    checkOutput("mid +16", {5'b0, rstNo}, 8'h01);
    waitEdges(8);
    checkOutput("mid +24", {5'b0, rstNo}, 8'h07);

    // Clear and set in the same cycle, then clear alone.
    applyStimulus(2'b01, 1'b1);
    waitEdges(1);
    checkOutput("clr+set cause", {5'b0, cause}, 8'h02);
    applyStimulus(2'b00, 1'b1);
    waitEdges(1);
    checkOutput("clr cause", {5'b0, cause}, 8'h00);
    applyStimulus(2'b00, 1'b0);

    // Request held high keeps everything asserted.
    applyStimulus(2'b11, 1'b0);
    waitEdges(30);
    checkOutput("held rst_no", {5'b0, rstNo}, 8'h00);
    checkOutput("held busy", {7'b0, busy}, 8'h01);
    applyStimulus(2'b00, 1'b0);
    waitEdges(16);
    checkOutput("held +16", {5'b0, rstNo}, 8'h01);
    checkOutput("held cause", {5'b0, cause}, 8'h06);

    randomPhase(800);

    // Asynchronous assertion from Run, checked before the next edge.
    waitEdges(40);
    checkOutput("run before async", {5'b0, rstNo}, 8'h07);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("async rst_no", {5'b0, rstNo}, 8'h00);
    checkOutput("async busy", {7'b0, busy}, 8'h01);
    checkOutput("async cause", {5'b0, cause}, 8'h01);
    checkOutput("async p1 rst_no", {7'b0, rstNo2}, 8'h00);
    waitEdges(3);
    @(negedge clk);
    #1 rst_ni = 1'b1;

    randomPhase(400);
    waitEdges(30);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
